// File: rtl/axis_pkt_packer.sv
// -----------------------------------------------------------------------------
// axis_pkt_packer
// Packs a 32-bit AXI-Stream, framed into bursts of BURST_BEATS beats with
// tlast on the final beat, into 128-bit words for the packet TX FIFO. Four
// consecutive accepted beats form one word, first beat in bits [31:0].
// Framing violations (early or missing tlast) flush the partial word with
// unfilled lanes zeroed and pulse frame_err. After a missing tlast the packer
// discards beats until the next tlast.
//
// Ports
//   PL_CLK, RESET            clock, synchronous active-high reset
//   S_AXIS_t*                32-bit input stream (tdata/tkeep/tlast/tvalid/tready)
//   fifo_wrreq_pkt_tx        registered write strobe to the packet FIFO
//   fifo_data_pkt_tx         registered 128-bit write data
//   fifo_prog_full_pkt_tx    FIFO programmable full, throttles tready
//   frame_err                one-cycle pulse per framing violation
//   frame_cnt                count of correctly framed frames (wraps)
//
// Build option
//   AXIS_PKT_PACKER_STAT_EN  adds keep_err_cnt (beats with tkeep != 4'hF) and
//                            drop_cnt (beats discarded while resyncing), both
//                            16-bit saturating. Without it tkeep is ignored.
// -----------------------------------------------------------------------------
module axis_pkt_packer #(
  parameter int BURST_BEATS = 16
) (
  input  logic         PL_CLK,
  input  logic         RESET,
  input  logic [31:0]  S_AXIS_tdata,
  input  logic [3:0]   S_AXIS_tkeep,
  input  logic         S_AXIS_tlast,
  input  logic         S_AXIS_tvalid,
  output logic         S_AXIS_tready,
  output logic         fifo_wrreq_pkt_tx,
  output logic [127:0] fifo_data_pkt_tx,
  input  logic         fifo_prog_full_pkt_tx,
  output logic         frame_err,
  output logic [15:0]  frame_cnt
`ifdef AXIS_PKT_PACKER_STAT_EN
  ,
  output logic [15:0]  keep_err_cnt,
  output logic [15:0]  drop_cnt
`endif
);

  localparam int BW = $clog2(BURST_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);

  localparam logic S_FILL   = 1'b0;
  localparam logic S_RESYNC = 1'b1;

  logic           state_q, state_d;
  logic [1:0]     lane_q, lane_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [127:0]   pack_q, pack_d;
  logic           wr_q, wr_d;
  logic [127:0]   data_q, data_d;
  logic           err_q, err_d;
  logic [15:0]    cnt_q, cnt_d;

  logic           acc;
  logic           last_beat;
  logic           emit;
  logic [127:0]   merged;

  // prog_full leaves at least two entries of margin, so the write launched
  // from the previous cycle's beat always fits.
  assign S_AXIS_tready = !fifo_prog_full_pkt_tx && !RESET;
  assign acc           = S_AXIS_tvalid && S_AXIS_tready;
  assign last_beat     = (beat_q == LAST_BEAT);
  // Current beat merged into its lane; lanes above it are still zero because
  // pack_q is cleared after every emit.
  assign merged        = pack_q | ({96'b0, S_AXIS_tdata} << {lane_q, 5'b0});
  assign emit          = S_AXIS_tlast || last_beat || (lane_q == 2'd3);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    pack_d  = pack_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (acc) begin
      if (state_q == S_FILL) begin
        if (emit) begin
          wr_d   = 1'b1;
          data_d = merged;
          pack_d = '0;
          lane_d = 2'd0;
          if (S_AXIS_tlast || last_beat) begin
            beat_d = '0;
            if (S_AXIS_tlast && last_beat) cnt_d = cnt_q + 16'd1;
            else                           err_d = 1'b1;
            // Missing tlast: the rest of this frame is discarded.
            if (!S_AXIS_tlast) state_d = S_RESYNC;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          pack_d = merged;
          lane_d = lane_q + 2'd1;
          beat_d = beat_q + 1'b1;
        end
      end else if (S_AXIS_tlast) begin
        state_d = S_FILL;
        lane_d  = 2'd0;
        beat_d  = '0;
      end
    end
  end

  always_ff @(posedge PL_CLK) begin
    if (RESET) begin
      state_q <= S_FILL;
      lane_q  <= 2'd0;
      beat_q  <= '0;
      pack_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      pack_q  <= pack_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_wrreq_pkt_tx = wr_q;
  assign fifo_data_pkt_tx  = data_q;
  assign frame_err         = err_q;
  assign frame_cnt         = cnt_q;

`ifdef AXIS_PKT_PACKER_STAT_EN
  logic [15:0] keep_q, drop_q;

  always_ff @(posedge PL_CLK) begin
    if (RESET) begin
      keep_q <= '0;
      drop_q <= '0;
    end else begin
      if (acc && (S_AXIS_tkeep != 4'hF) && (keep_q != 16'hFFFF))
        keep_q <= keep_q + 16'd1;
      if (acc && (state_q == S_RESYNC) && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 16'd1;
    end
  end

  assign keep_err_cnt = keep_q;
  assign drop_cnt     = drop_q;
`else
  logic unused_keep;
  assign unused_keep = ^S_AXIS_tkeep;
`endif

endmodule

// File: tb/tb_axis_pkt_packer.sv
module tb_axis_pkt_packer;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  tdata;
  logic [3:0]   tkeep;
  logic         tlast, tvalid, tready;
  logic         wr;
  logic [127:0] wdata;
  logic         pf;
  logic         ferr;
  logic [15:0]  fcnt;
`ifdef AXIS_PKT_PACKER_STAT_EN
  logic [15:0]  keep_cnt, drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_pkt_packer #(.BURST_BEATS(16)) dut (
    .PL_CLK(clk), .RESET(rst),
    .S_AXIS_tdata(tdata), .S_AXIS_tkeep(tkeep), .S_AXIS_tlast(tlast),
    .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready),
    .fifo_wrreq_pkt_tx(wr), .fifo_data_pkt_tx(wdata),
    .fifo_prog_full_pkt_tx(pf),
    .frame_err(ferr), .frame_cnt(fcnt)
`ifdef AXIS_PKT_PACKER_STAT_EN
    , .keep_err_cnt(keep_cnt), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic         v;
    logic [31:0]  d;
    logic [3:0]   k;
    logic         l;
    logic         pf;
    logic         etr;
    logic         ewr;
    logic [127:0] edat;
    logic         eerr;
    logic [15:0]  ecnt;
  } vec_t;

  vec_t tbl[$];
  logic [15:0] cnt_m;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic [31:0] d, input logic [3:0] k,
                      input logic l, input logic p, input logic ewr,
                      input logic [127:0] edat, input logic eerr);
    vec_t e;
    e.v = v; e.d = d; e.k = k; e.l = l; e.pf = p; e.etr = !p;
    e.ewr = ewr; e.edat = edat; e.eerr = eerr; e.ecnt = cnt_m;
    tbl.push_back(e);
  endtask

  // Correctly framed 16-beat frame of data base+i; beats flagged in badk carry tkeep=7.
  task automatic good_frame(input logic [31:0] b, input logic [15:0] badk);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) cnt_m = cnt_m + 16'd1;
      push(1'b1, b + 32'(i), badk[i] ? 4'h7 : 4'hF, i == 15, 1'b0, (i % 4) == 3,
           {b + 32'(i), b + 32'(i - 1), b + 32'(i - 2), b + 32'(i - 3)}, 1'b0);
    end
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[n]) begin
      tvalid = tbl[n].v; tdata = tbl[n].d; tkeep = tbl[n].k;
      tlast = tbl[n].l; pf = tbl[n].pf;
      #1;
      chk($sformatf("%s[%0d].tready", tag, n), 128'(tready), 128'(tbl[n].etr));
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].wrreq", tag, n), 128'(wr), 128'(tbl[n].ewr));
      if (tbl[n].ewr) chk($sformatf("%s[%0d].data", tag, n), wdata, tbl[n].edat);
      chk($sformatf("%s[%0d].frame_err", tag, n), 128'(ferr), 128'(tbl[n].eerr));
      chk($sformatf("%s[%0d].frame_cnt", tag, n), 128'(fcnt), 128'(tbl[n].ecnt));
    end
    tvalid = 1'b0; tlast = 1'b0;
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; pf = 1'b0; tkeep = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt_m = 16'd0;
  endtask

  task automatic rnd_test();
    int f = 0, b = 0, cyc = 0;
    logic [31:0] w[4];
    logic acc, pfv;
    tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF;
    while (f < 100 && cyc < 40000) begin
      pfv = ((cyc / 7) % 2) == 1;
      pf = pfv;
      if (!tvalid) begin
        tvalid = 1'($urandom_range(0, 1));
        tdata  = $urandom;
        tlast  = (b == 15);
      end
      #1;
      chk("rnd.tready", 128'(tready), 128'(!pfv));
      acc = tvalid && !pfv;
      @(posedge clk); #1;
      chk("rnd.wrreq", 128'(wr), 128'(acc && (b % 4) == 3));
      if (acc && (b % 4) == 3)
        chk("rnd.data", wdata, {tdata, w[2], w[1], w[0]});
      chk("rnd.frame_err", 128'(ferr), 128'(0));
      cyc++;
      if (acc) begin
        w[b % 4] = tdata;
        b++;
        if (b == 16) begin b = 0; f++; end
        tvalid = 1'b0;
      end
    end
    if (cyc >= 40000) chk("rnd.timeout", 128'(1), 128'(0));
    tvalid = 1'b0; tlast = 1'b0; pf = 1'b0;
    chk("rnd.frame_cnt", 128'(fcnt), 128'(100));
  endtask

  initial begin
    tdata = '0; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b0; pf = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.wrreq", 128'(wr), 128'(0));
    chk("rst.data", wdata, 128'(0));
    chk("rst.frame_err", 128'(ferr), 128'(0));
    chk("rst.frame_cnt", 128'(fcnt), 128'(0));
    chk("rst.tready", 128'(tready), 128'(0));
`ifdef AXIS_PKT_PACKER_STAT_EN
    chk("rst.keep_err_cnt", 128'(keep_cnt), 128'(0));
    chk("rst.drop_cnt", 128'(drop_cnt), 128'(0));
`endif
    rst = 1'b0;
    cnt_m = 16'd0;

    // Full frame, short frame, idle/backpressure gaps, then a good frame.
    good_frame(32'h0, 16'h0);
    push(1'b1, 32'hA0, 4'hF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    push(1'b1, 32'hA1, 4'hF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    push(1'b0, 32'hDEAD, 4'hF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    push(1'b1, 32'hBAD0, 4'hF, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    push(1'b1, 32'hA2, 4'hF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    push(1'b1, 32'hA3, 4'hF, 1'b0, 1'b0, 1'b1,
         128'h000000A3_000000A2_000000A1_000000A0, 1'b0);
    push(1'b1, 32'hA4, 4'hF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    push(1'b1, 32'hA5, 4'hF, 1'b1, 1'b0, 1'b1,
         128'h00000000_00000000_000000A5_000000A4, 1'b1);
    push(1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    good_frame(32'h100, 16'h0);
    run_tbl("basic");

    // Long frame: 20 beats, tlast on beat 19; beats 16..19 dropped.
    for (int i = 0; i < 16; i++)
      push(1'b1, 32'h200 + 32'(i), 4'hF, 1'b0, 1'b0, (i % 4) == 3,
           {32'h200 + 32'(i), 32'h1FF + 32'(i), 32'h1FE + 32'(i), 32'h1FD + 32'(i)},
           i == 15);
    for (int i = 16; i < 20; i++)
      push(1'b1, 32'h200 + 32'(i), 4'hF, i == 19, 1'b0, 1'b0, '0, 1'b0);
    good_frame(32'h300, 16'h0);
    run_tbl("long");
`ifdef AXIS_PKT_PACKER_STAT_EN
    chk("long.drop_cnt", 128'(drop_cnt), 128'(4));
`endif

    // Reset for one cycle after beat 2 of a frame.
    for (int i = 0; i < 3; i++) push(1'b1, 32'h400 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    run_tbl("prerst");
    tvalid = 1'b1; tdata = 32'h403; rst = 1'b1;
    #1 chk("midrst.tready", 128'(tready), 128'(0));
    @(posedge clk); #1;
    chk("midrst.wrreq", 128'(wr), 128'(0));
    chk("midrst.frame_err", 128'(ferr), 128'(0));
    chk("midrst.frame_cnt", 128'(fcnt), 128'(0));
`ifdef AXIS_PKT_PACKER_STAT_EN
    chk("midrst.drop_cnt", 128'(drop_cnt), 128'(0));
`endif
    rst = 1'b0; tvalid = 1'b0;
    cnt_m = 16'd0;
    good_frame(32'h500, 16'h0);
    // Three tkeep=7 beats inside a good frame: data unchanged, no frame_err.
    good_frame(32'h600, 16'b0000_0010_0010_0100);
    run_tbl("postrst");
`ifdef AXIS_PKT_PACKER_STAT_EN
    chk("keep.keep_err_cnt", 128'(keep_cnt), 128'(3));
`endif

    do_reset();
    rnd_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
